axi_lite_arbiter: RTL and testbench

Shares one AXI4-Lite master port among NUM_REQ local requesters. Each requester issues single-beat read/write commands over a valid/ready request channel. A round-robin arbiter picks one command at a time and sequences the full AXI4-Lite transaction (AR/R or AW+W/B) on `m_axi_lite`. It then returns the read data and response to the winning requester. The block sits between on-chip register clients and the AXI-Lite interconnect, in place of a single hard-wired master.

---
 rtl/axi_pkg.sv | 13 +
 rtl/axi_lite_if.sv | 62 ++++++
 rtl/axi_lite_rr_arb.sv | 45 ++++
 rtl/axi_lite_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4-Lite widths and response codes.
// Imported by the arbiter, its interface and its sub-module.
package axi_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle with master/slave modports.
// Five channels, single beat, no ids.
interface axi_lite_if
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = axi_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_pkg::DATA_WIDTH
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_lite_rr_arb.sv
// Requester picker: round-robin from a start pointer, or
// fixed lowest-index priority when AXI_LITE_ARB_FIXED_PRIO_EN.
module axi_lite_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  logic           w_found;
  logic [IDX_W:0] w_pos;

  // first set request in search order wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos = (IDX_W+1)'(i);
      if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
        w_found = 1'b1;
        o_idx   = w_pos[IDX_W-1:0];
        o_gnt[w_pos[IDX_W-1:0]] = 1'b1;
      end
    end
`else
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_pos >= (IDX_W+1)'(NUM_REQ))
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
        w_found = 1'b1;
        o_idx   = w_pos[IDX_W-1:0];
        o_gnt[w_pos[IDX_W-1:0]] = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/axi_lite_arbiter.sv
// Shares one AXI4-Lite master among NUM_REQ requesters.
// Option macro: AXI_LITE_ARB_FIXED_PRIO_EN (fixed priority).
module axi_lite_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = axi_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_pkg::DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rdata,
  output logic [1:0]                          rsp_resp,
  axi_lite_if.master                          m_axi_lite
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP,
    S_RSP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic [IDX_W-1:0]      w_ptr;
  logic                  w_accept;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_b_hs;

  logic                  w_arvalid;
  logic                  w_rready;
  logic                  w_awvalid;
  logic                  w_wvalid;
  logic                  w_bready;

  axi_lite_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req (req_valid),
    .i_ptr (w_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  // ready is forced low while reset is held
  assign w_accept = (r_state == S_IDLE) && rst && (|req_valid);

  assign w_ar_hs = w_arvalid && m_axi_lite.arready;
  assign w_r_hs  = w_rready  && m_axi_lite.rvalid;
  assign w_aw_hs = w_awvalid && m_axi_lite.awready;
  assign w_w_hs  = w_wvalid  && m_axi_lite.wready;
  assign w_b_hs  = w_bready  && m_axi_lite.bvalid;

`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IDX_W-1:0] r_ptr;

  assign w_ptr = r_ptr;

  // pointer moves past the winner on every accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      if (w_gnt_idx == IDX_W'(NUM_REQ-1))
        r_ptr <= '0;
      else
        r_ptr <= w_gnt_idx + IDX_W'(1);
    end
  end
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = req_write[w_gnt_idx] ? S_WREQ : S_RADDR;
      end
      S_RADDR: if (w_ar_hs) w_state_nxt = S_RDATA;
      S_RDATA: if (w_r_hs)  w_state_nxt = S_RSP;
      S_WREQ: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
          w_state_nxt = S_WRESP;
      end
      S_WRESP: if (w_b_hs) w_state_nxt = S_RSP;
      S_RSP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_accept) req_ready = w_gnt;
      S_RADDR: w_arvalid = 1'b1;
      S_RDATA: w_rready  = 1'b1;
      S_WREQ: begin
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
      end
      S_WRESP: w_bready = 1'b1;
      S_RSP:   rsp_valid[r_idx] = 1'b1;
      default: ;
    endcase
  end

  // command capture on accept, response capture on R/B
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_idx   <= '0;
      r_rdata <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      if (w_accept) begin
        r_write <= req_write[w_gnt_idx];
        r_addr  <= req_addr[w_gnt_idx];
        r_wdata <= req_wdata[w_gnt_idx];
        r_wstrb <= req_wstrb[w_gnt_idx];
        r_idx   <= w_gnt_idx;
      end
      if (w_r_hs) begin
        r_rdata <= m_axi_lite.rdata;
        r_resp  <= m_axi_lite.rresp;
      end
      if (w_b_hs) begin
        r_rdata <= '0;
        r_resp  <= m_axi_lite.bresp;
      end
    end
  end

  // AW and W complete independently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_resp  = r_resp;

  assign m_axi_lite.araddr  = r_addr;
  assign m_axi_lite.arprot  = 3'b000;
  assign m_axi_lite.arvalid = w_arvalid;
  assign m_axi_lite.rready  = w_rready;
  assign m_axi_lite.awaddr  = r_addr;
  assign m_axi_lite.awprot  = 3'b000;
  assign m_axi_lite.awvalid = w_awvalid;
  assign m_axi_lite.wdata   = r_wdata;
  assign m_axi_lite.wstrb   = r_wstrb;
  assign m_axi_lite.wvalid  = w_wvalid;
  assign m_axi_lite.bready  = w_bready;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter with a
// delay-programmable AXI4-Lite slave model.
module tb_axi_lite_arbiter;
  import axi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]        req_valid = '0;
  logic [3:0]        req_ready;
  logic [3:0]        req_write = '0;
  logic [3:0][31:0]  req_addr  = '0;
  logic [3:0][31:0]  req_wdata = '0;
  logic [3:0][3:0]   req_wstrb = '0;
  logic [3:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi_lite_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .m_axi_lite (axi.master)
  );

  // slave model configuration
  int          ar_delay = 0;
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          r_delay  = 0;
  logic [31:0] rdata_cfg = '0;
  logic [1:0]  rresp_cfg = RESP_OKAY;
  logic [1:0]  bresp_cfg = RESP_OKAY;
  bit          rdata_by_addr = 1'b0;

  int          ar_cnt, aw_cnt, w_cnt, r_cnt;
  logic        r_pend, b_pend, aw_got, w_got;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  int          awv_cycles = 0;
  int          wv_cycles = 0;
  int          bready_early = 0;

  assign axi.arready = axi.arvalid && (ar_cnt >= ar_delay);
  assign axi.rvalid  = r_pend && (r_cnt >= r_delay);
  assign axi.rdata   = rdata_by_addr ? {16'hC0DE, s_araddr[15:0]}
                                     : rdata_cfg;
  assign axi.rresp   = rresp_cfg;
  assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
  assign axi.wready  = axi.wvalid && (w_cnt >= w_delay);
  assign axi.bvalid  = b_pend;
  assign axi.bresp   = bresp_cfg;

  // slave model: counts valid cycles to delay each ready
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0;
      aw_got <= 1'b0; w_got <= 1'b0;
      s_araddr <= '0; s_awaddr <= '0;
      s_wdata <= '0; s_wstrb <= '0;
    end else begin
      if (axi.arvalid && !axi.arready) ar_cnt <= ar_cnt + 1;
      else ar_cnt <= 0;
      if (axi.arvalid && axi.arready) begin
        r_pend <= 1'b1;
        s_araddr <= axi.araddr;
      end
      if (r_pend && !axi.rvalid) r_cnt <= r_cnt + 1;
      if (axi.rvalid && axi.rready) begin
        r_pend <= 1'b0;
        r_cnt <= 0;
      end
      if (axi.awvalid && !axi.awready) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (axi.wvalid && !axi.wready) w_cnt <= w_cnt + 1;
      else w_cnt <= 0;
      if (axi.awvalid && axi.awready) begin
        aw_got <= 1'b1;
        s_awaddr <= axi.awaddr;
      end
      if (axi.wvalid && axi.wready) begin
        w_got <= 1'b1;
        s_wdata <= axi.wdata;
        s_wstrb <= axi.wstrb;
      end
      if (!b_pend &&
          (aw_got || (axi.awvalid && axi.awready)) &&
          (w_got || (axi.wvalid && axi.wready)))
        b_pend <= 1'b1;
      if (axi.bvalid && axi.bready) begin
        b_pend <= 1'b0;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end
      if (axi.awvalid) awv_cycles <= awv_cycles + 1;
      if (axi.wvalid)  wv_cycles  <= wv_cycles + 1;
      if (axi.bready && !(aw_got && w_got))
        bready_early <= bready_early + 1;
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_ptr = 0;

  function automatic int pick(logic [3:0] pend, int ptr);
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++)
      if (pend[i]) return i;
`else
    for (int i = 0; i < 4; i++)
      if (pend[(ptr + i) % 4]) return (ptr + i) % 4;
`endif
    return 0;
  endfunction

  function automatic void note_accept(int g);
`ifndef AXI_LITE_ARB_FIXED_PRIO_EN
    m_ptr = (g + 1) % 4;
`endif
  endfunction

  task automatic run_cmd(input int idx, input bit wr,
                         input logic [31:0] addr,
                         input logic [31:0] data,
                         input logic [3:0] strb,
                         input logic [31:0] exp_rd,
                         input logic [1:0] exp_rs,
                         input int exp_lat,
                         input string name);
    exp_t e;
    int t0;
    bit got;
    logic [3:0] oh;
    @(negedge clk);
    req_write[idx] = wr;
    req_addr[idx]  = addr;
    req_wdata[idx] = data;
    req_wstrb[idx] = strb;
    req_valid[idx] = 1'b1;
    #1;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready != 4'b0) begin got = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s accept: no req_ready, want bit %0d", name, idx);
      req_valid[idx] = 1'b0;
      return;
    end
    oh = 4'b0001 << idx;
    n_cmp++;
    if (req_ready !== oh) begin
      n_err++;
      $display("FAIL %s ready: got %b want %b", name, req_ready, oh);
    end
    note_accept(idx);
    e.idx = idx;
    e.rdata = wr ? 32'h0 : exp_rd;
    e.resp = exp_rs;
    q.push_back(e);
    t0 = cyc;
    @(posedge clk);
    #1 req_valid[idx] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s rsp: no rsp_valid, want bit %0d", name, idx);
      void'(q.pop_front());
      return;
    end
    e = q.pop_front();
    oh = 4'b0001 << e.idx;
    n_cmp++;
    if (rsp_valid !== oh) begin
      n_err++;
      $display("FAIL %s rsp_valid: got %b want %b", name, rsp_valid, oh);
    end
    n_cmp++;
    if (rsp_rdata !== e.rdata) begin
      n_err++;
      $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, e.rdata);
    end
    n_cmp++;
    if (rsp_resp !== e.resp) begin
      n_err++;
      $display("FAIL %s resp: got %b want %b", name, rsp_resp, e.resp);
    end
    if (exp_lat > 0) begin
      n_cmp++;
      if (cyc - t0 != exp_lat) begin
        n_err++;
        $display("FAIL %s latency: got %0d want %0d", name, cyc - t0, exp_lat);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 4'b0) begin
      n_err++;
      $display("FAIL %s pulse: rsp_valid %b want 0000", name, rsp_valid);
    end
  endtask

  task automatic run_pool(input logic [3:0] mask, input bit cont,
                          input int n, input int exp_gap,
                          input string name);
    logic [3:0] pend;
    logic [3:0] oh;
    logic [31:0] a;
    int grants;
    int last;
    int g;
    exp_t e;
    pend = mask;
    grants = 0;
    last = -1;
    rdata_by_addr = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_write[i] = 1'b0;
      req_addr[i]  = 32'h100 + 32'(i * 16);
    end
    req_valid = mask;
    #1;
    for (int k = 0; k < 400 && (grants < n || q.size() > 0); k++) begin
      if (req_ready != 4'b0) begin
        g = pick(pend, m_ptr);
        oh = 4'b0001 << g;
        n_cmp++;
        if (req_ready !== oh) begin
          n_err++;
          $display("FAIL %s grant%0d: got %b want %b", name, grants, req_ready, oh);
        end
        if (last >= 0 && exp_gap > 0) begin
          n_cmp++;
          if (cyc - last != exp_gap) begin
            n_err++;
            $display("FAIL %s gap: got %0d want %0d", name, cyc - last, exp_gap);
          end
        end
        last = cyc;
        note_accept(g);
        a = 32'h100 + 32'(g * 16);
        e.idx = g;
        e.rdata = {16'hC0DE, a[15:0]};
        e.resp = RESP_OKAY;
        q.push_back(e);
        grants++;
        if (!cont) pend[g] = 1'b0;
        @(posedge clk);
        #1 req_valid = (grants >= n) ? 4'b0 : pend;
      end else if (rsp_valid != 4'b0) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL %s extra rsp: rsp_valid %b want none", name, rsp_valid);
        end else begin
          e = q.pop_front();
          oh = 4'b0001 << e.idx;
          if (rsp_valid !== oh || rsp_rdata !== e.rdata ||
              rsp_resp !== e.resp) begin
            n_err++;
            $display("FAIL %s rsp: got %b/%h/%b want %b/%h/%b", name,
                     rsp_valid, rsp_rdata, rsp_resp, oh, e.rdata, e.resp);
          end
        end
      end
      @(negedge clk);
    end
    req_valid = 4'b0;
    rdata_by_addr = 1'b0;
    n_cmp++;
    if (grants != n || q.size() != 0) begin
      n_err++;
      $display("FAIL %s done: grants %0d pending %0d want %0d/0",
               name, grants, q.size(), n);
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    rst = 1'b0;
    req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    outs = {req_ready, rsp_valid, axi.arvalid, axi.awvalid,
            axi.wvalid, axi.rready, axi.bready, 1'b0,
            rsp_resp, 2'b0, 4'b0, rsp_rdata, 8'b0};
    n_cmp++;
    if (outs !== 64'h0) begin
      n_err++;
      $display("FAIL reset outputs: got %h want 0", outs);
    end
    n_cmp++;
    if (axi.araddr !== 32'h0) begin
      n_err++;
      $display("FAIL reset araddr: got %h want 0", axi.araddr);
    end
    req_valid = 4'b0;
    rst = 1'b1;
    m_ptr = 0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    ar_delay = 0; r_delay = 0;
    rdata_cfg = 32'hdeadbeef;
    rresp_cfg = RESP_OKAY;
    run_cmd(0, 1'b0, 32'h10, 32'h0, 4'h0,
            32'hdeadbeef, RESP_OKAY, 3, "read0");
    n_cmp++;
    if (s_araddr !== 32'h10) begin
      n_err++;
      $display("FAIL read0 araddr: got %h want 00000010", s_araddr);
    end
  endtask

  task automatic test_write();
    int awv0, wv0, be0;
    aw_delay = 3; w_delay = 0;
    bresp_cfg = RESP_OKAY;
    awv0 = awv_cycles; wv0 = wv_cycles; be0 = bready_early;
    run_cmd(2, 1'b1, 32'h20, 32'h12345678, 4'hF,
            32'h0, RESP_OKAY, 6, "write2");
    n_cmp++;
    if (awv_cycles - awv0 != 4) begin
      n_err++;
      $display("FAIL write2 awvalid cycles: got %0d want 4", awv_cycles - awv0);
    end
    n_cmp++;
    if (wv_cycles - wv0 != 1) begin
      n_err++;
      $display("FAIL write2 wvalid cycles: got %0d want 1", wv_cycles - wv0);
    end
    n_cmp++;
    if (bready_early != be0) begin
      n_err++;
      $display("FAIL write2 early bready: got %0d want %0d", bready_early, be0);
    end
    n_cmp++;
    if (s_awaddr !== 32'h20 || s_wdata !== 32'h12345678 || s_wstrb !== 4'hF) begin
      n_err++;
      $display("FAIL write2 payload: got %h/%h/%h want 20/12345678/f",
               s_awaddr, s_wdata, s_wstrb);
    end
    aw_delay = 0;
    bresp_cfg = RESP_DECERR;
    run_cmd(3, 1'b1, 32'h24, 32'hcafef00d, 4'h3,
            32'h0, RESP_DECERR, 3, "write3_min");
    w_delay = 2;
    bresp_cfg = RESP_OKAY;
    run_cmd(1, 1'b1, 32'h28, 32'h0badf00d, 4'h5,
            32'h0, RESP_OKAY, 5, "write1_wlate");
    n_cmp++;
    if (s_wdata !== 32'h0badf00d || s_wstrb !== 4'h5) begin
      n_err++;
      $display("FAIL write1 payload: got %h/%h want 0badf00d/5", s_wdata, s_wstrb);
    end
    w_delay = 0;
  endtask

  task automatic test_round_robin();
    do_reset();
    run_pool(4'hF, 1'b1, 5, 4, "rr");
  endtask

  task automatic test_slverr();
    rdata_cfg = 32'hbadc0ffe;
    rresp_cfg = RESP_SLVERR;
    run_cmd(1, 1'b0, 32'h30, 32'h0, 4'h0,
            32'hbadc0ffe, RESP_SLVERR, 3, "slverr");
    rdata_cfg = 32'h600df00d;
    rresp_cfg = RESP_OKAY;
    run_cmd(3, 1'b0, 32'h34, 32'h0, 4'h0,
            32'h600df00d, RESP_OKAY, 3, "after_slverr");
  endtask

  task automatic test_reset_mid();
    logic [11:0] outs;
    bit got;
    int seen;
    r_delay = 6;
    @(negedge clk);
    req_write[2] = 1'b0;
    req_addr[2] = 32'h40;
    req_valid[2] = 1'b1;
    #1;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready[2]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (got) note_accept(2);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (axi.rready) begin got = 1'b1; break; end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL rst_mid reach rdata: rready 0 want 1");
    end
    #2 rst = 1'b0;
    #1;
    outs = {req_ready, rsp_valid, axi.arvalid, axi.awvalid,
            axi.wvalid, axi.rready};
    n_cmp++;
    if (outs !== 12'h0 || axi.bready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid handshakes: got %h want 0", outs);
    end
    n_cmp++;
    if (rsp_rdata !== 32'h0 || rsp_resp !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid rsp: got %h/%b want 0/00", rsp_rdata, rsp_resp);
    end
    m_ptr = 0;
    r_delay = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) seen++;
    end
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid != 4'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_mid stray rsp: got %0d pulses want 0", seen);
    end
    run_pool(4'b1010, 1'b0, 2, 0, "post_rst");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_slverr();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
